difftest_int_wb_source: RTL and testbench
=========================================

Name: difftest_int_wb_source

Overview:
- Transmit end of the difftest integer-writeback interface.
- Accepts up to two architectural integer register writebacks per cycle from the commit stage and buffers them in a FIFO.
- Serialises them into a one-event-per-cycle stream (enable/io_valid/io_address/io_data/io_coreid), which feeds the difftest integer-writeback sink.
- The sink has no backpressure, so this block owns all flow control toward commit.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 4.
- COREID, 0, 8-bit constant driven on io_coreid.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  2  per-lane writeback request; lane 0 is older than lane 1.
- in_addr0  input  5  lane 0 register index.
- in_data0  input  64  lane 0 write data.
- in_addr1  input  5  lane 1 register index.
- in_data1  input  64  lane 1 write data.
- in_ready  output  1  high when free entries >= 2.
- enable  output  1  sink call strobe, registered.
- io_valid  output  1  equals enable.
- io_address  output  5  register index of the emitted event.
- io_data  output  64  data of the emitted event.
- io_coreid  output  8  constant COREID.
- occupancy  output  log2(DEPTH)+1  current FIFO entry count.
- drop_cnt  output  16  count of writebacks offered while in_ready was low; saturates.

Behaviour:
- Reset, checked synchronously:
  - FIFO pointers and occupancy go to 0.
  - enable, io_valid, io_address and io_data go to 0; drop_cnt goes to 0.
  - io_coreid is always COREID.
- Accept rule:
  - Lanes with in_valid set are written in the cycle that in_ready is high.
  - Lane 0 is written before lane 1.
  - With only in_valid[1] set, lane 1 takes a single entry.
  - Accept is all-or-nothing; there is never a partial accept.
- in_ready is combinational from occupancy only: (DEPTH - occupancy) >= 2. It does not depend on in_valid.
- Offers while in_ready is low: drop_cnt increments by popcount(in_valid) and saturates at 0xFFFF. The data is discarded; commit must hold it and retry.
- Emit rule:
  - Each cycle with occupancy > 0 at the clock edge, the head entry is popped and registered onto io_address/io_data, with enable = 1 the next cycle.
  - Otherwise enable = 0; io_address/io_data keep their last values.
- Latency: a writeback accepted into an empty FIFO appears on the outputs the cycle after acceptance. There is no same-cycle bypass.
- Ordering: emission is strictly FIFO. Lane 0 precedes lane 1 within a cycle, and earlier cycles precede later ones.
- Simultaneous push and pop: occupancy_next = occupancy + pushes - pop.
  - When the FIFO is full-minus-one, the pop in the same cycle does not raise in_ready; in_ready is computed on current occupancy.
- Wrap-around: pointers are log2(DEPTH)+1 bits wide.
  - Full means the MSBs differ and the low bits are equal.
  - Empty means the pointers are equal.
  - Wrap is seamless.
- Reset mid-operation discards all buffered entries. enable is 0 on the cycle after reset is asserted.
- There are no X outputs after reset.
- State machine (2-bit):
  - IDLE: occupancy = 0.
  - STREAM: occupancy in 1..DEPTH-2.
  - STALL: occupancy >= DEPTH-1, in_ready low.
  - The state is derived from next occupancy each cycle and is exposed for assertions only.

Optional Feature:
- Macro DIFFTEST_WB_X0_FILTER_EN.
- Defined:
  - A lane with address 0 is treated as not valid. It is not pushed and not counted in drop_cnt.
  - in_ready is unaffected.
  - If both lanes target x0, nothing is written.
- Undefined: x0 writes are buffered and emitted like any other register.

Test Plan:
1. After reset, single lane 0 write of (addr 5, data 0xDEAD_BEEF) -> next cycle: enable=1, io_address=5, io_data=0xDEADBEEF, io_coreid=COREID. The cycle after: enable=0, occupancy=0.
2. Dual-lane write (addr 1, data 0x11) and (addr 2, data 0x22) in one cycle -> two consecutive emits in order addr 1 then addr 2. Occupancy sequence 2, 1, 0.
3. Back-to-back dual writes for 8 cycles with DEPTH=8 -> in_ready drops when occupancy reaches 7. drop_cnt counts the rejected lanes. Retried data is emitted in order with no loss and no duplication.
4. Fill the FIFO past one pointer wrap (20 dual writes with retries) -> the emitted addr/data sequence exactly matches the accepted sequence across the wrap.
5. Reset asserted with occupancy 5 -> next cycle: enable=0, occupancy=0. A subsequent write of addr 7 emits correctly with no stale entries.
6. DIFFTEST_WB_X0_FILTER_EN defined; lanes (addr 0, 0x1) and (addr 3, 0x3) -> only addr 3 is emitted, and occupancy peaks at 1. With the macro undefined, both are emitted.

Source files
------------

// File: rtl/difftest_int_wb_source.sv
// -----------------------------------------------------------------------------
// difftest_int_wb_source
//   Transmit end of the difftest integer-writeback interface. Takes up to two
//   architectural integer writebacks per cycle from commit, buffers them in a
//   FIFO and serialises them into a one-event-per-cycle stream for the sink.
//   The sink has no backpressure, so flow control toward commit lives here.
//
// Optional feature: define DIFFTEST_WB_X0_FILTER_EN to drop lanes that target
//   x0 (not pushed, not counted as drops). in_ready is unaffected.
//
// Parameters:
//   DEPTH   FIFO entries (power of two, >= 4)
//   COREID  constant driven on io_coreid
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid[1:0]         per-lane request, lane 0 older than lane 1
//   in_addr0/in_data0     lane 0 register index / data
//   in_addr1/in_data1     lane 1 register index / data
//   in_ready              free entries >= 2 (depends on occupancy only)
//   enable, io_valid      registered sink strobe (io_valid mirrors enable)
//   io_address, io_data   emitted event, held when enable is low
//   io_coreid             constant COREID
//   occupancy             current FIFO entry count
//   drop_cnt              saturating count of lanes offered while not ready
// -----------------------------------------------------------------------------
module difftest_int_wb_source #(
  parameter int DEPTH  = 8,
  parameter int COREID = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [1:0]                 in_valid,
  input  logic [4:0]                 in_addr0,
  input  logic [63:0]                in_data0,
  input  logic [4:0]                 in_addr1,
  input  logic [63:0]                in_data1,
  output logic                       in_ready,
  output logic                       enable,
  output logic                       io_valid,
  output logic [4:0]                 io_address,
  output logic [63:0]                io_data,
  output logic [7:0]                 io_coreid,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [15:0]                drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_STALL  = 2'd2;

  logic [4:0]    addr_mem [DEPTH];
  logic [63:0]   data_mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] occ;
  logic [PW-1:0] occ_next;
  logic [PW-1:0] wr_ptr_l1;
  logic [1:0]    lane_v;
  logic [1:0]    push_cnt;
  logic [1:0]    drop_inc;
  logic [16:0]   drop_sum;
  logic          pop_en;
  logic          empty;
  logic          full;
  logic [1:0]    state;
  logic [1:0]    state_next;

`ifdef DIFFTEST_WB_X0_FILTER_EN
  assign lane_v = in_valid & {in_addr1 != 5'd0, in_addr0 != 5'd0};
`else
  assign lane_v = in_valid;
`endif

  assign occ       = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = (occ <= PW'(DEPTH - 2));
  assign pop_en    = !empty;
  assign push_cnt  = {1'b0, lane_v[0]} + {1'b0, lane_v[1]};
  // Lane 1 lands directly behind lane 0, or at the tail when lane 0 is idle.
  assign wr_ptr_l1 = wr_ptr + PW'(lane_v[0]);
  assign drop_inc  = in_ready ? 2'd0 : push_cnt;
  assign drop_sum  = {1'b0, drop_cnt} + 17'(drop_inc);
  assign occ_next  = occ + PW'(in_ready ? push_cnt : 2'd0) - PW'(pop_en);

  assign occupancy = occ;
  assign io_valid  = enable;
  assign io_coreid = 8'(COREID);

  always_comb begin
    state_next = ST_STREAM;
    if (occ_next == '0) begin
      state_next = ST_IDLE;
    end else if (occ_next >= PW'(DEPTH - 1)) begin
      state_next = ST_STALL;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (!reset && in_ready) begin
      if (lane_v[0]) begin
        addr_mem[wr_ptr[AW-1:0]] <= in_addr0;
        data_mem[wr_ptr[AW-1:0]] <= in_data0;
      end
      if (lane_v[1]) begin
        addr_mem[wr_ptr_l1[AW-1:0]] <= in_addr1;
        data_mem[wr_ptr_l1[AW-1:0]] <= in_data1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      enable     <= 1'b0;
      io_address <= '0;
      io_data    <= '0;
      drop_cnt   <= '0;
      state      <= ST_IDLE;
    end else begin
      if (in_ready) begin
        wr_ptr <= wr_ptr + PW'(push_cnt);
      end
      enable <= pop_en;
      if (pop_en) begin
        io_address <= addr_mem[rd_ptr[AW-1:0]];
        io_data    <= data_mem[rd_ptr[AW-1:0]];
        rd_ptr     <= rd_ptr + PW'(1);
      end
      if (!in_ready) begin
        drop_cnt <= drop_sum[16] ? '1 : drop_sum[15:0];
      end
      state <= state_next;
    end
  end

  // Pushes need two free slots and every non-empty cycle pops, so the FIFO
  // never actually reaches the full pointer condition.
  a_stall_ready : assert property (@(posedge clock) disable iff (reset)
                                   (state == ST_STALL) == !in_ready);
  a_idle_empty  : assert property (@(posedge clock) disable iff (reset)
                                   (state == ST_IDLE) == empty);
  a_never_full  : assert property (@(posedge clock) disable iff (reset) !full);

endmodule

// File: tb/tb_difftest_int_wb_source.sv
module tb_difftest_int_wb_source;

  localparam int DEPTH  = 8;
  localparam int COREID = 8'h5A;
  localparam int PW     = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    in_valid = '0;
  logic [4:0]    in_addr0 = '0;
  logic [63:0]   in_data0 = '0;
  logic [4:0]    in_addr1 = '0;
  logic [63:0]   in_data1 = '0;
  logic          in_ready;
  logic          enable;
  logic          io_valid;
  logic [4:0]    io_address;
  logic [63:0]   io_data;
  logic [7:0]    io_coreid;
  logic [PW-1:0] occupancy;
  logic [15:0]   drop_cnt;

  always #5 clock = ~clock;

  difftest_int_wb_source #(.DEPTH(DEPTH), .COREID(COREID)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .in_addr0(in_addr0), .in_data0(in_data0),
    .in_addr1(in_addr1), .in_data1(in_data1),
    .in_ready(in_ready), .enable(enable), .io_valid(io_valid),
    .io_address(io_address), .io_data(io_data), .io_coreid(io_coreid),
    .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
  } ent_t;

  // Reference model: a plain queue of pending writebacks plus expected outputs.
  ent_t        q[$];
  logic        exp_en   = 1'b0;
  logic [4:0]  exp_addr = '0;
  logic [63:0] exp_data = '0;
  int          exp_drop = 0;
  int          tests    = 0;
  int          fails    = 0;
  int          dut_emits = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lane_ok(input logic v, input logic [4:0] a);
`ifdef DIFFTEST_WB_X0_FILTER_EN
    return (v && a != 5'd0) ? 1 : 0;
`else
    return v ? 1 : 0;
`endif
  endfunction

  task automatic check_outputs();
    chk("enable",    64'(enable),     64'(exp_en));
    chk("io_valid",  64'(io_valid),   64'(exp_en));
    chk("io_address",64'(io_address), 64'(exp_addr));
    chk("io_data",   io_data,         exp_data);
    chk("io_coreid", 64'(io_coreid),  64'(COREID));
    chk("occupancy", 64'(occupancy),  64'(q.size()));
    chk("drop_cnt",  64'(drop_cnt),   64'(exp_drop));
  endtask

  // One clock cycle: drive, check in_ready, advance model at the edge, check outputs.
  task automatic step(input logic rst, input logic [1:0] v,
                      input logic [4:0] a0, input logic [63:0] d0,
                      input logic [4:0] a1, input logic [63:0] d1,
                      output bit acc);
    bit   ready;
    ent_t e;
    int   n;
    @(negedge clock);
    reset = rst; in_valid = v;
    in_addr0 = a0; in_data0 = d0; in_addr1 = a1; in_data1 = d1;
    #1;
    ready = (q.size() <= DEPTH - 2);
    chk("in_ready", 64'(in_ready), 64'(ready));
    @(posedge clock);
    if (rst) begin
      q.delete();
      exp_en = 1'b0; exp_addr = '0; exp_data = '0; exp_drop = 0;
      acc = 1'b0;
    end else begin
      if (q.size() > 0) begin
        e = q.pop_front();
        exp_en = 1'b1; exp_addr = e.a; exp_data = e.d;
      end else begin
        exp_en = 1'b0;
      end
      acc = ready;
      if (ready) begin
        if (lane_ok(v[0], a0) != 0) q.push_back('{a: a0, d: d0});
        if (lane_ok(v[1], a1) != 0) q.push_back('{a: a1, d: d1});
      end else begin
        n = lane_ok(v[0], a0) + lane_ok(v[1], a1);
        exp_drop = (exp_drop + n > 65535) ? 65535 : exp_drop + n;
      end
    end
    #1;
    if (enable) dut_emits++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, '0, '0, '0, acc);
  endtask

  task automatic do_reset();
    bit acc;
    step(1'b1, 2'b00, '0, '0, '0, '0, acc);
    step(1'b1, 2'b00, '0, '0, '0, '0, acc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          acc;
    int          k;
    int          accepted;
    int          base;
    logic [1:0]  pv;
    logic [4:0]  pa0, pa1;
    logic [63:0] pd0, pd1;
    bit          pending;

    do_reset();
    chk("reset_enable", 64'(enable), 64'd0);
    chk("reset_occ",    64'(occupancy), 64'd0);
    chk("reset_drop",   64'(drop_cnt), 64'd0);
    chk("reset_addr",   64'(io_address), 64'd0);
    chk("reset_data",   io_data, 64'd0);

    // Single lane 0 write, one-cycle latency.
    step(1'b0, 2'b01, 5'd5, 64'hDEAD_BEEF, '0, '0, acc);
    chk("t1_occ", 64'(occupancy), 64'd1);
    idle(1);
    chk("t1_en",   64'(enable), 64'd1);
    chk("t1_addr", 64'(io_address), 64'd5);
    chk("t1_data", io_data, 64'hDEAD_BEEF);
    chk("t1_core", 64'(io_coreid), 64'h5A);
    idle(1);
    chk("t1_en_off", 64'(enable), 64'd0);
    chk("t1_occ0",   64'(occupancy), 64'd0);
    chk("t1_hold",   64'(io_address), 64'd5);

    // Dual lane in one cycle: lane 0 first.
    step(1'b0, 2'b11, 5'd1, 64'h11, 5'd2, 64'h22, acc);
    chk("t2_occ2", 64'(occupancy), 64'd2);
    idle(1);
    chk("t2_addr1", 64'(io_address), 64'd1);
    chk("t2_occ1",  64'(occupancy), 64'd1);
    idle(1);
    chk("t2_addr2", 64'(io_address), 64'd2);
    chk("t2_data2", io_data, 64'h22);
    chk("t2_occ0",  64'(occupancy), 64'd0);

    // Back-to-back dual writes with retry until stall.
    do_reset();
    k = 0;
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 2'b11, 5'(1 + (k % 30)), 64'(k), 5'(2 + (k % 30)), 64'(k + 1000), acc);
      if (acc) k++;
    end
    chk("t3_drop",  64'(drop_cnt), 64'd2);
    chk("t3_occ7",  64'(occupancy), 64'd7);
    chk("t3_ready", 64'(in_ready), 64'd0);
    idle(2 * DEPTH);

    // 20 accepted dual writes crossing pointer wraps.
    base = dut_emits;
    accepted = 0;
    for (int c = 0; c < 200 && accepted < 20; c++) begin
      step(1'b0, 2'b11, 5'(1 + (accepted % 31)), {$urandom, $urandom},
           5'(1 + ((accepted + 7) % 31)), {$urandom, $urandom}, acc);
      if (acc) accepted++;
    end
    chk("t4_accepted", 64'(accepted), 64'd20);
    idle(2 * DEPTH);
    chk("t4_emits", 64'(dut_emits - base), 64'd40);

    // Reset mid-operation with occupancy 5.
    do_reset();
    for (int c = 0; c < 4; c++) step(1'b0, 2'b11, 5'(10 + c), 64'(c), 5'(20 + c), 64'(c), acc);
    chk("t5_occ5", 64'(occupancy), 64'd5);
    step(1'b1, 2'b00, '0, '0, '0, '0, acc);
    chk("t5_en0",  64'(enable), 64'd0);
    chk("t5_occ0", 64'(occupancy), 64'd0);
    step(1'b0, 2'b01, 5'd7, 64'h77, '0, '0, acc);
    idle(1);
    chk("t5_addr7", 64'(io_address), 64'd7);
    chk("t5_data",  io_data, 64'h77);
    idle(1);
    chk("t5_done", 64'(enable), 64'd0);

    // x0 lane handling.
    step(1'b0, 2'b11, 5'd0, 64'h1, 5'd3, 64'h3, acc);
`ifdef DIFFTEST_WB_X0_FILTER_EN
    chk("t6_occ", 64'(occupancy), 64'd1);
    idle(1);
    chk("t6_addr", 64'(io_address), 64'd3);
    idle(1);
    chk("t6_en", 64'(enable), 64'd0);
`else
    chk("t6_occ", 64'(occupancy), 64'd2);
    idle(1);
    chk("t6_addr0", 64'(io_address), 64'd0);
    idle(1);
    chk("t6_addr3", 64'(io_address), 64'd3);
`endif
    idle(2);

    // Randomised traffic with commit-style retry and occasional resets.
    pending = 1'b0;
    pv = '0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int c = 0; c < 500; c++) begin
      if (!pending) begin
        pv  = 2'($urandom_range(0, 3));
        pa0 = 5'($urandom_range(0, 31));
        pa1 = 5'($urandom_range(0, 31));
        pd0 = {$urandom, $urandom};
        pd1 = {$urandom, $urandom};
      end
      if ($urandom_range(0, 99) == 0) begin
        step(1'b1, pv, pa0, pd0, pa1, pd1, acc);
        pending = 1'b0;
      end else begin
        step(1'b0, pv, pa0, pd0, pa1, pd1, acc);
        pending = !acc && (pv != 2'b00);
      end
    end
    idle(2 * DEPTH);
    chk("final_occ", 64'(occupancy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
